// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device over the shared open-drain ps2_clk/ps2_data
// lines. Only pull-low enables are produced; the pad level builds the tristates.
// The keyboard receiver sharing these lines should ignore them while busy is high.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [SS-1:0]     r_clkSync;
    logic [SS-1:0]     r_dataSync;
    logic              r_clkPrev;
    logic [8:0]        r_shift;
    logic [3:0]        r_bitCnt;
    logic [INH_W-1:0]  r_inhCnt;
    logic [TO_W-1:0]   r_toCnt;
    logic              r_dataOe;
    logic              r_done;
    logic              r_error;
    logic              w_clkS;
    logic              w_dataS;
    logic              w_fall;
    logic              w_timeout;
    logic              w_doneSet;
    logic              w_errorSet;

    // Bring both line inputs into the clock domain; idle lines read as high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkSync  <= '1;
            r_dataSync <= '1;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[SS-2:0], ps2_clk};
            r_dataSync <= {r_dataSync[SS-2:0], ps2_data};
            r_clkPrev  <= w_clkS;
        end
    end

    assign w_clkS    = r_clkSync[SS-1];
    assign w_dataS   = r_dataSync[SS-1];
    assign w_fall    = r_clkPrev & ~w_clkS;
    assign w_timeout = ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE))
                       && (r_toCnt == TO_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a timeout wins over a clock fall in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_doneSet   = 1'b0;
        w_errorSet  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_nextState = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inhCnt == INH_LAST) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                w_nextState = S_SEND;
            end
            S_SEND: begin
                if (w_timeout) begin
                    w_nextState = S_IDLE;
                    w_errorSet  = 1'b1;
                end else if (w_fall && (r_bitCnt == 4'd9)) begin
                    w_nextState = S_ACK;
                end
            end
            S_ACK: begin
                if (w_timeout) begin
                    w_nextState = S_IDLE;
                    w_errorSet  = 1'b1;
                end else if (w_fall) begin
                    if (w_dataS) begin
                        w_nextState = S_IDLE;
                        w_errorSet  = 1'b1;
                    end else begin
                        w_nextState = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_timeout) begin
                    w_nextState = S_IDLE;
                    w_errorSet  = 1'b1;
                end else if (w_clkS && w_dataS) begin
                    w_nextState = S_IDLE;
                    w_doneSet   = 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: byte/parity latch, inhibit and timeout counters, bit shifting,
    // and the done/error pulses that land in the first IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_inhCnt <= '0;
            r_toCnt  <= '0;
            r_dataOe <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= w_doneSet;
            r_error <= w_errorSet;
            case (r_state)
                S_IDLE: begin
                    r_inhCnt <= '0;
                    r_dataOe <= 1'b0;
                    if (tx_valid) begin
                        r_shift <= {~^tx_data, tx_data};
                    end
                end
                S_INHIBIT: begin
                    r_inhCnt <= r_inhCnt + INH_W'(1);
                end
                S_REQ: begin
                    r_bitCnt <= '0;
                    r_toCnt  <= '0;
                    r_dataOe <= 1'b1;
                end
                S_SEND: begin
                    r_toCnt <= r_toCnt + TO_W'(1);
                    if (w_fall && !w_timeout) begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                        if (r_bitCnt <= 4'd8) begin
                            r_dataOe <= ~r_shift[r_bitCnt];
                        end else begin
                            r_dataOe <= 1'b0;
                        end
                    end
                end
                S_ACK, S_WAIT_IDLE: begin
                    r_toCnt <= r_toCnt + TO_W'(1);
                end
                default: begin
                    r_dataOe <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign ps2_data_oe = (r_state == S_REQ) || ((r_state == S_SEND) && r_dataOe);
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain line model and a
// behavioural PS/2 device that clocks frames and answers with ACK/NACK/silence.
module tb_ps2_host_tx;

    localparam int INHIBIT = 8;
    localparam int TIMEOUT = 4000;

    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_ABORT  = 3;

    localparam int RES_DONE    = 1;
    localparam int RES_NACK    = 2;
    localparam int RES_TIMEOUT = 3;

    logic       clk;
    logic       rst;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       clkOe;
    logic       dataOe;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2ClkLine;
    logic       ps2DataLine;
    logic       devClkLow;
    logic       devDataLow;
    logic       abortReq;
    int         devMode;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int releaseCyc = 0;
    int inhRun = 0;
    int reqRun = 0;
    logic prevClkOe = 1'b0;
    int expRes;
    logic [10:0] devFrame;

    logic [10:0] expFrameQ[$];
    int          expResultQ[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(txData),
        .tx_valid(txValid),
        .tx_ready(txReady),
        .ps2_clk(ps2ClkLine),
        .ps2_data(ps2DataLine),
        .ps2_clk_oe(clkOe),
        .ps2_data_oe(dataOe),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // Wired-AND of the open-drain lines: low if either side pulls.
    assign ps2ClkLine  = ~(clkOe | devClkLow);
    assign ps2DataLine = ~(dataOe | devDataLow);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter advanced on the active edge so negedge readers agree.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference frame as the device should see it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] expectFrame(input logic [7:0] b);
        logic [10:0] f;
        int v;
        int ones;
        f = '0;
        v = int'(b);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = (v % 2) != 0;
            ones += v % 2;
            v = v / 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input int mode, input bit holdValid);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!txReady && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        if (!txReady) begin
            checkOutput("ready before send", {31'b0, txReady}, 1);
            return;
        end
        devMode = mode;
        txData  = b;
        txValid = 1'b1;
        if (mode == MODE_ACK || mode == MODE_NACK) expFrameQ.push_back(expectFrame(b));
        if (mode == MODE_ACK) expResultQ.push_back(RES_DONE);
        if (mode == MODE_NACK) expResultQ.push_back(RES_NACK);
        if (mode == MODE_SILENT) expResultQ.push_back(RES_TIMEOUT);
        @(posedge clk);
        #1;
        checkOutput("accepted busy", {31'b0, busy}, 1);
        if (holdValid) begin
            repeat (40) begin
                @(negedge clk);
                txData = 8'($urandom);
            end
        end
        @(negedge clk);
        txValid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((expResultQ.size() != 0 || !txReady) && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("transfer completes", expResultQ.size(), 0);
        repeat (250) @(negedge clk);
    endtask

    // Line monitor: measures inhibit/request lengths and records the clock release time.
    always @(negedge clk) begin
        if (rst) begin
            inhRun    = 0;
            reqRun    = 0;
            prevClkOe = 1'b0;
        end else begin
            if (clkOe && !dataOe) begin
                inhRun++;
            end else if (clkOe && dataOe) begin
                reqRun++;
            end else begin
                if (prevClkOe) begin
                    releaseCyc = cyc;
                    checkOutput("inhibit length", inhRun, INHIBIT);
                    checkOutput("request length", reqRun, 1);
                end
                inhRun = 0;
                reqRun = 0;
            end
            prevClkOe = clkOe;
        end
    end

    // Result monitor: every done/error pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (done || error) begin
            if (expResultQ.size() == 0) begin
                checkOutput("spurious pulse", {30'b0, done, error}, 0);
            end else begin
                expRes = expResultQ.pop_front();
                checkOutput("outcome done/error", {30'b0, done, error},
                            (expRes == RES_DONE) ? 32'd2 : 32'd1);
                checkOutput("ready with pulse", {31'b0, txReady}, 1);
                checkOutput("lines released at pulse", {30'b0, clkOe, dataOe}, 0);
                if (expRes == RES_TIMEOUT) begin
                    checkOutput("timeout latency", cyc - releaseCyc, TIMEOUT);
                end
            end
        end
    end

    // Device model: answers a request-to-send by clocking 11 pulses at 1/200 clk.
    initial begin : deviceModel
        int mode;
        int guard;
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        abortReq   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && busy && !clkOe && !ps2DataLine) begin
                mode = devMode;
                if (mode != MODE_SILENT) begin
                    repeat (50) @(negedge clk);
                    devFrame    = '0;
                    devFrame[0] = ps2DataLine;
                    for (int k = 1; k <= 11; k++) begin
                        devClkLow = 1'b1;
                        repeat (100) @(negedge clk);
                        devClkLow = 1'b0;
                        if (k <= 10) devFrame[k] = ps2DataLine;
                        else devDataLow = 1'b0;
                        if (mode == MODE_ABORT && k == 4) begin
                            abortReq = 1'b1;
                            break;
                        end
                        if (k < 11) begin
                            repeat (50) @(negedge clk);
                            if (k == 10 && mode == MODE_ACK) devDataLow = 1'b1;
                            repeat (50) @(negedge clk);
                        end
                    end
                    if (mode == MODE_ACK || mode == MODE_NACK) begin
                        if (expFrameQ.size() == 0) checkOutput("frame without request", 1, 0);
                        else checkOutput("frame bits", {21'b0, devFrame}, {21'b0, expFrameQ.pop_front()});
                    end
                end
                if (mode == MODE_SILENT || mode == MODE_ABORT) begin
                    guard = 0;
                    while (busy && guard < 6000) begin
                        @(negedge clk);
                        guard++;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [7:0] b;
        int guard;
        int mode;
        rst     = 1'b1;
        txValid = 1'b0;
        txData  = 8'h00;
        devMode = MODE_ACK;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_ready", {31'b0, txReady}, 1);
        checkOutput("reset busy", {31'b0, busy}, 0);
        checkOutput("reset done/error", {30'b0, done, error}, 0);
        checkOutput("reset oe", {30'b0, clkOe, dataOe}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        applyStimulus(8'hED, MODE_ACK, 1'b0);
        waitIdle();

        applyStimulus(8'h00, MODE_ACK, 1'b0);
        applyStimulus(8'h01, MODE_ACK, 1'b0);
        waitIdle();

        applyStimulus(8'h5A, MODE_NACK, 1'b0);
        waitIdle();
        checkOutput("idle after nack", {29'b0, txReady, clkOe, dataOe}, 32'd4);

        applyStimulus(8'h3C, MODE_SILENT, 1'b0);
        waitIdle();

        b = 8'($urandom) & 8'hF7;
        applyStimulus(b, MODE_ABORT, 1'b0);
        guard = 0;
        while (!abortReq && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort point reached", {31'b0, abortReq}, 1);
        checkOutput("data driven before reset", {30'b0, clkOe, dataOe}, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async release on reset", {30'b0, clkOe, dataOe}, 0);
        checkOutput("ready during reset", {30'b0, txReady, busy}, 2);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        abortReq = 1'b0;
        repeat (250) @(negedge clk);

        applyStimulus(8'hFF, MODE_ACK, 1'b0);
        waitIdle();

        applyStimulus(8'($urandom), MODE_ACK, 1'b1);
        waitIdle();

        for (int i = 0; i < 6; i++) begin
            mode = ($urandom_range(0, 3) == 0) ? MODE_NACK : MODE_ACK;
            applyStimulus(8'($urandom), mode, 1'b0);
            waitIdle();
        end

        checkOutput("frames pending", expFrameQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
